ps2_axi_ctrl: RTL and testbench
===============================

# ps2_axi_ctrl

PS/2 keyboard/mouse receiver with a parametrised scan-code FIFO and a small AXI4 register file. It sits on the peripheral crossbar as a 64-bit AXI4 slave. It adds the following over the fixed 8-entry receiver:
- configurable FIFO depth
- frame timeout recovery
- sticky overflow and frame-error flags
- a writable control register (flush and flag clear)
- an optional interrupt

## Interface
Parameters:
- FIFO_DEPTH, 16, scan-code FIFO entries; power of two, ≥2
- TIMEOUT_CYCLES, 50000, clock cycles without a ps2_clk falling edge before a partial frame is abandoned; 0 disables the timeout
- CNT_W, $clog2(FIFO_DEPTH)+1, occupancy counter width (derived)

Ports:
- clock  in  1  system clock; all logic in this single domain
- resetn  in  1  asynchronous, active-low reset
- ps2_clk, ps2_dat  in  1 each  raw PS/2 lines; asynchronous to clock
- io_slave_aw{ready,valid,addr,id,len,size,burst}  AXI4 AW: ready out 1, valid in 1, addr in 32, id in 4, len in 8, size in 3, burst in 2
- io_slave_w{ready,valid,data,strb,last}  AXI4 W: ready out 1, valid in 1, data in 64, strb in 8, last in 1
- io_slave_b{ready,valid,resp,id}  AXI4 B: ready in 1, valid out 1, resp out 2, id out 4
- io_slave_ar{ready,valid,addr,id,len,size,burst}  AXI4 AR: same widths and directions as AW
- io_slave_r{ready,valid,resp,data,last,id}  AXI4 R: ready in 1, valid out 1, resp out 2, data out 64, last out 1, id out 4
- irq  out  1  level interrupt; present only with PS2_IRQ_EN

## Operation
**Receiver**
- ps2_clk passes through a 2-flop synchroniser and an edge register. A sample strobe fires on each synchronised falling edge.
- An 11-bit frame is collected by a 4-bit bit counter: start, D0..D7, parity, stop.
- On the 11th strobe, the frame is accepted when all of these hold: start==0, stop (ps2_dat)==1, and odd parity over D0..D7 plus the parity bit. Otherwise the frame is discarded and frame_err is set.
- The bit counter returns to 0 after every 11th strobe.
- Timeout: a counter runs whenever the bit counter is nonzero and clears on each strobe. When it reaches TIMEOUT_CYCLES, the bit counter returns to 0 and frame_err is set.

**FIFO**
- Accepted byte is pushed. If the FIFO is full, the byte is dropped and overflow is set.
- Pointers are CNT_W-1 bits wide and wrap naturally.
- Simultaneous push and pop: both take effect and occupancy is unchanged. This includes the full case: a pop frees a slot, so the push is accepted.
- Flush in the same cycle as a push: flush wins, the FIFO is empty, and the byte is lost (no overflow).

**Register map** (decoded on addr[4:3]; data in bits [31:0] of the 64-bit bus, upper 32 bits read 0)
- 0x00 DATA (read): pops one entry and returns {23'b0, 1'b1, code[7:0]}. When empty, returns 0 and does not pop.
- 0x08 STATUS (read-only): [CNT_W-1:0] occupancy, [16] overflow, [17] frame_err, [18] empty, [19] full.
- 0x10 CTRL (write, honoured only when wstrb[0]=1):
  - bit0 flush
  - bit1 clear overflow
  - bit2 clear frame_err
  - bit3 irq_en
  - Bits 0–2 are self-clearing pulses. A read returns {31'b0, irq_en} placed at bit 3.
- 0x18 reads 0. Writes to any register other than CTRL are ignored.
- A flag set and a flag clear in the same cycle: set wins.

**AXI behaviour**
- Single-beat only. len, size and burst are ignored; rlast=1 with every rvalid.
- resp is always OKAY (2'b00). rid and bid echo the captured arid and awid.
- Read FSM:
  - R_IDLE: arready=1. On AR handshake, capture address and id, perform the pop and data capture, go to R_DATA.
  - R_DATA: rvalid=1. On rready, return to R_IDLE.
- Write FSM:
  - W_ADDR: awready=1. On AW handshake, go to W_DATA.
  - W_DATA: wready=1. On W handshake, apply CTRL and go to W_RESP.
  - W_RESP: bvalid=1. On bready, return to W_ADDR.
- Read and write FSMs run independently.

## Timing
- Reset values:
  - arready=1, awready=1
  - wready=0, rvalid=0, bvalid=0
  - rdata=0, rlast=0, rid=0, bid=0, rresp=0, bresp=0
  - irq=0
  - FIFO empty, all flags 0, irq_en=0, bit counter 0
- Reset asserted mid-frame or mid-transaction aborts everything. The bus master must not expect a pending response after reset.
- Strobe latency: 3 clock cycles after the raw ps2_clk falling edge.
- Push completes on the clock edge of the 11th strobe. A STATUS read whose AR handshake occurs at the next edge or later shows it.
- Read: AR handshake at edge N gives rvalid high from N+1. Data reflects FIFO state before edge N. The pop is committed at edge N.
- Write: minimum 3 cycles AW→B. CTRL effects are visible from the edge following the W handshake.

## Configuration
- PS2_IRQ_EN defined:
  - irq port exists.
  - irq is registered: irq = irq_en & (!empty | overflow | frame_err).
  - irq updates one cycle after the underlying condition.
- PS2_IRQ_EN undefined:
  - No irq port and no irq logic.
  - CTRL bit3 is ignored and reads 0.

## Test plan
- Send valid frame 0x1C (parity 0) → STATUS occupancy=1, empty=0. DATA read returns 0x11C. Second DATA read returns 0x000.
- Frame with bad parity (0x1C, parity bit 1) → FIFO stays empty, STATUS[17]=1. Write CTRL=0x4 → STATUS[17]=0.
- Send FIFO_DEPTH+1 frames (0x01..0x11 with DEPTH=16) → full=1, overflow=1. Sixteen DATA reads return 0x101..0x110 in order.
- Send 4 data bits, then idle TIMEOUT_CYCLES+10 cycles, then a valid 0x5A frame → frame_err=1 and DATA returns 0x15A.
- With the FIFO full, a DATA pop coincides with a 0x33 push → occupancy stays 16 and overflow stays 0. Writing CTRL=0x1 in the same cycle as a push empties the FIFO.
- With PS2_IRQ_EN: CTRL=0x8, then push 0x29 → irq=1 one cycle after the push. DATA read → irq=0 one cycle after the pop.

Source files
------------

// File: rtl/ps2_axi_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : ps2_axi_ctrl
//  Purpose  : PS/2 receiver feeding a scan-code FIFO, exposed through a
//             single-beat 64-bit AXI4 slave register file.
//             Optional feature macro: PS2_IRQ_EN (irq port + CTRL.irq_en).
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_axi_ctrl #(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic        io_slave_awready,
    input  logic        io_slave_awvalid,
    input  logic [31:0] io_slave_awaddr,
    input  logic [3:0]  io_slave_awid,
    input  logic [7:0]  io_slave_awlen,
    input  logic [2:0]  io_slave_awsize,
    input  logic [1:0]  io_slave_awburst,
    output logic        io_slave_wready,
    input  logic        io_slave_wvalid,
    input  logic [63:0] io_slave_wdata,
    input  logic [7:0]  io_slave_wstrb,
    input  logic        io_slave_wlast,
    input  logic        io_slave_bready,
    output logic        io_slave_bvalid,
    output logic [1:0]  io_slave_bresp,
    output logic [3:0]  io_slave_bid,
    output logic        io_slave_arready,
    input  logic        io_slave_arvalid,
    input  logic [31:0] io_slave_araddr,
    input  logic [3:0]  io_slave_arid,
    input  logic [7:0]  io_slave_arlen,
    input  logic [2:0]  io_slave_arsize,
    input  logic [1:0]  io_slave_arburst,
    input  logic        io_slave_rready,
    output logic        io_slave_rvalid,
    output logic [1:0]  io_slave_rresp,
    output logic [63:0] io_slave_rdata,
    output logic        io_slave_rlast,
    output logic [3:0]  io_slave_rid
`ifdef PS2_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic       R_IDLE = 1'b0;
    localparam logic       R_DATA = 1'b1;
    localparam logic [1:0] W_ADDR = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    logic [1:0]       r_clk_sync, r_dat_sync;
    logic             r_clk_prev;
    logic [3:0]       r_bitcnt;
    logic [9:0]       r_frame;
    logic [31:0]      r_tocnt;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [CNT_W-2:0] r_wptr, r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf, r_ferr;
    logic             r_rstate, w_rnext;
    logic [1:0]       r_wstate, w_wnext;
    logic [31:0]      r_rdata;
    logic [3:0]       r_rid, r_bid;
    logic [1:0]       r_awsel;
    logic             w_strobe, w_last, w_accept, w_timeout;
    logic             w_full, w_empty, w_push, w_pop, w_ovf_set;
    logic             w_ar_hs, w_aw_hs, w_w_hs, w_ctrl_wr;
    logic             w_flush, w_clr_ovf, w_clr_ferr, w_irq_en;
    logic [31:0]      w_status, w_rd_word;
    logic             w_unused_ok;

    assign w_unused_ok = ^{io_slave_awaddr[31:5], io_slave_awaddr[2:0], io_slave_awlen,
                           io_slave_awsize, io_slave_awburst, io_slave_araddr[31:5],
                           io_slave_araddr[2:0], io_slave_arlen, io_slave_arsize,
                           io_slave_arburst, io_slave_wdata[63:3], io_slave_wstrb[7:1],
                           io_slave_wlast};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_dat};
            r_clk_prev <= r_clk_sync[1];
        end
    end

    // Frame is shifted LSB-first: after ten strobes [0]=start, [8:1]=data, [9]=parity.
    assign w_strobe  = r_clk_prev & ~r_clk_sync[1];
    assign w_last    = w_strobe && (r_bitcnt == 4'd10);
    assign w_accept  = w_last && !r_frame[0] && r_dat_sync[1] && (^r_frame[9:1]);
    assign w_timeout = (TIMEOUT_CYCLES != 0) && !w_strobe && (r_bitcnt != 4'd0) &&
                       (r_tocnt == 32'(TIMEOUT_CYCLES));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_bitcnt <= 4'd0;
            r_frame  <= 10'd0;
            r_tocnt  <= 32'd0;
        end else begin
            if (w_strobe)
                r_frame <= {r_dat_sync[1], r_frame[9:1]};
            if (w_last || w_timeout)
                r_bitcnt <= 4'd0;
            else if (w_strobe)
                r_bitcnt <= r_bitcnt + 4'd1;
            if (w_strobe || w_timeout || (r_bitcnt == 4'd0))
                r_tocnt <= 32'd0;
            else
                r_tocnt <= r_tocnt + 32'd1;
        end
    end

    assign w_ar_hs    = (r_rstate == R_IDLE) && io_slave_arvalid;
    assign w_aw_hs    = (r_wstate == W_ADDR) && io_slave_awvalid;
    assign w_w_hs     = (r_wstate == W_DATA) && io_slave_wvalid;
    assign w_ctrl_wr  = w_w_hs && (r_awsel == 2'd2) && io_slave_wstrb[0];
    assign w_flush    = w_ctrl_wr & io_slave_wdata[0];
    assign w_clr_ovf  = w_ctrl_wr & io_slave_wdata[1];
    assign w_clr_ferr = w_ctrl_wr & io_slave_wdata[2];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop     = w_ar_hs && (io_slave_araddr[4:3] == 2'd0) && !w_empty;
    assign w_push    = w_accept && (!w_full || w_pop) && !w_flush;
    assign w_ovf_set = w_accept && w_full && !w_pop && !w_flush;

    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wptr] <= r_frame[8:1];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            if (w_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
                if (w_push && !w_pop)
                    r_count <= r_count + CNT_W'(1);
                else if (w_pop && !w_push)
                    r_count <= r_count - CNT_W'(1);
            end
            r_ovf  <= w_ovf_set | (r_ovf & ~w_clr_ovf);
            r_ferr <= (w_last && !w_accept) | w_timeout | (r_ferr & ~w_clr_ferr);
        end
    end

`ifdef PS2_IRQ_EN
    logic r_irq_en, r_irq;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_ctrl_wr)
                r_irq_en <= io_slave_wdata[3];
            r_irq <= r_irq_en & (!w_empty | r_ovf | r_ferr);
        end
    end
    assign w_irq_en = r_irq_en;
    assign irq      = r_irq;
`else
    assign w_irq_en = 1'b0;
`endif

    assign w_status = 32'(r_count) | {12'd0, w_full, w_empty, r_ferr, r_ovf, 16'd0};

    always_comb begin
        w_rd_word = 32'd0;
        case (io_slave_araddr[4:3])
            2'd0:    if (!w_empty) w_rd_word = {23'd0, 1'b1, r_mem[r_rptr]};
            2'd1:    w_rd_word = w_status;
            2'd2:    w_rd_word = {28'd0, w_irq_en, 3'd0};
            default: w_rd_word = 32'd0;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rstate <= R_IDLE;
            r_wstate <= W_ADDR;
        end else begin
            r_rstate <= w_rnext;
            r_wstate <= w_wnext;
        end
    end

    always_comb begin
        w_rnext = r_rstate;
        case (r_rstate)
            R_IDLE:  if (io_slave_arvalid) w_rnext = R_DATA;
            default: if (io_slave_rready)  w_rnext = R_IDLE;
        endcase
        w_wnext = r_wstate;
        case (r_wstate)
            W_ADDR:  if (io_slave_awvalid) w_wnext = W_DATA;
            W_DATA:  if (io_slave_wvalid)  w_wnext = W_RESP;
            W_RESP:  if (io_slave_bready)  w_wnext = W_ADDR;
            default: w_wnext = W_ADDR;
        endcase
    end

    always_comb begin
        io_slave_arready = (r_rstate == R_IDLE);
        io_slave_rvalid  = (r_rstate == R_DATA);
        io_slave_rlast   = (r_rstate == R_DATA);
        io_slave_rresp   = 2'b00;
        io_slave_rdata   = {32'd0, r_rdata};
        io_slave_rid     = r_rid;
        io_slave_awready = (r_wstate == W_ADDR);
        io_slave_wready  = (r_wstate == W_DATA);
        io_slave_bvalid  = (r_wstate == W_RESP);
        io_slave_bresp   = 2'b00;
        io_slave_bid     = r_bid;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rdata <= 32'd0;
            r_rid   <= 4'd0;
            r_bid   <= 4'd0;
            r_awsel <= 2'd0;
        end else begin
            if (w_ar_hs) begin
                r_rdata <= w_rd_word;
                r_rid   <= io_slave_arid;
            end
            if (w_aw_hs) begin
                r_awsel <= io_slave_awaddr[4:3];
                r_bid   <= io_slave_awid;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_axi_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ps2_axi_ctrl
//  Purpose  : Self-checking bench for ps2_axi_ctrl (queue scoreboard model).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_axi_ctrl;

    localparam int DEPTH = 16;
    localparam int TO    = 200;
    localparam int HALF  = 10;

    logic        clock = 1'b0, resetn = 1'b0, ps2_clk = 1'b1, ps2_dat = 1'b1;
    logic        awready, awvalid = 1'b0, wready, wvalid = 1'b0, wlast = 1'b1;
    logic        bready = 1'b1, bvalid, arready, arvalid = 1'b0, rready = 1'b1, rvalid, rlast;
    logic [31:0] awaddr = '0, araddr = '0;
    logic [3:0]  awid = '0, arid = '0, bid, rid;
    logic [63:0] wdata = '0, rdata;
    logic [7:0]  wstrb = '0;
    logic [1:0]  bresp, rresp;
`ifdef PS2_IRQ_EN
    logic        irq;
`endif

    ps2_axi_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .io_slave_awready(awready), .io_slave_awvalid(awvalid), .io_slave_awaddr(awaddr),
        .io_slave_awid(awid), .io_slave_awlen(8'd0), .io_slave_awsize(3'd2),
        .io_slave_awburst(2'd1), .io_slave_wready(wready), .io_slave_wvalid(wvalid),
        .io_slave_wdata(wdata), .io_slave_wstrb(wstrb), .io_slave_wlast(wlast),
        .io_slave_bready(bready), .io_slave_bvalid(bvalid), .io_slave_bresp(bresp),
        .io_slave_bid(bid), .io_slave_arready(arready), .io_slave_arvalid(arvalid),
        .io_slave_araddr(araddr), .io_slave_arid(arid), .io_slave_arlen(8'd0),
        .io_slave_arsize(3'd2), .io_slave_arburst(2'd1), .io_slave_rready(rready),
        .io_slave_rvalid(rvalid), .io_slave_rresp(rresp), .io_slave_rdata(rdata),
        .io_slave_rlast(rlast), .io_slave_rid(rid)
`ifdef PS2_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] code;
        bit         bad_par;
        bit         bad_stop;
        bit         rd_data;
    } vec_t;

    int          n_chk = 0, n_err = 0, id_ctr = 1;
    logic [31:0] sb[$];
    bit          m_ovf = 0, m_ferr = 0, m_irq_en = 0;
    logic [3:0]  last_awid = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic to_fail(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: handshake timed out", name);
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = 32'(sb.size());
        s[16] = m_ovf;
        s[17] = m_ferr;
        s[18] = (sb.size() == 0);
        s[19] = (sb.size() == DEPTH);
        return s;
    endfunction

    function automatic void apply_ctrl(input logic [3:0] d);
        if (d[0]) sb.delete();
        if (d[1]) m_ovf = 0;
        if (d[2]) m_ferr = 0;
`ifdef PS2_IRQ_EN
        m_irq_en = d[3];
`endif
    endfunction

    // Caller is at a negedge; the handshake lands on the following posedge.
    task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
        logic [3:0] id;
        int k;
        id = 4'(id_ctr);
        id_ctr++;
        arvalid = 1'b1; araddr = a; arid = id;
        k = 0;
        while (!arready && k < 20) begin @(negedge clock); k++; end
        if (!arready) begin to_fail("ar_wait"); arvalid = 1'b0; d = '0; return; end
        @(posedge clock); #1 arvalid = 1'b0;
        @(negedge clock);
        k = 0;
        while (!rvalid && k < 20) begin @(negedge clock); k++; end
        if (!rvalid) begin to_fail("r_wait"); d = '0; return; end
        d = rdata[31:0];
        check("r_meta", {rdata[63:32], rid, rlast, rresp}, {32'd0, id, 1'b1, 2'b00});
    endtask

    task automatic aw_phase(input logic [31:0] a);
        int k;
        last_awid = 4'(id_ctr);
        id_ctr++;
        awvalid = 1'b1; awaddr = a; awid = last_awid;
        k = 0;
        while (!awready && k < 20) begin @(negedge clock); k++; end
        if (!awready) begin to_fail("aw_wait"); awvalid = 1'b0; return; end
        @(posedge clock); #1 awvalid = 1'b0;
    endtask

    task automatic w_phase(input logic [63:0] dat, input logic [7:0] strb);
        int k;
        wvalid = 1'b1; wdata = dat; wstrb = strb;
        k = 0;
        while (!wready && k < 20) begin @(negedge clock); k++; end
        if (!wready) begin to_fail("w_wait"); wvalid = 1'b0; return; end
        @(posedge clock); #1 wvalid = 1'b0;
        @(negedge clock);
        k = 0;
        while (!bvalid && k < 20) begin @(negedge clock); k++; end
        if (!bvalid) begin to_fail("b_wait"); return; end
        check("b_meta", {bid, bresp}, {last_awid, 2'b00});
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clock);
        axi_read(a, d);
    endtask

    task automatic wr(input logic [31:0] a, input logic [63:0] dat, input logic [7:0] strb);
        @(negedge clock);
        aw_phase(a);
        @(negedge clock);
        w_phase(dat, strb);
    endtask

    task automatic chk_status(input string name);
        logic [31:0] d;
        rd(32'h08, d);
        check(name, d, exp_status());
    endtask

    task automatic chk_data(input string name);
        logic [31:0] d;
        rd(32'h00, d);
        check(name, d, (sb.size() != 0) ? sb.pop_front() : 32'd0);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b1;
    endtask

    // mode 0: plain frame; 1: DATA pop on the push edge; 2: CTRL flush on the push edge;
    // 3: irq timing around the push edge.
    task automatic ps2_send(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                            input int mode);
        logic [31:0] d;
        logic        par;
        bit          ok;
        par = (~^code) ^ bad_par;
        ok  = !bad_par && !bad_stop;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i]);
        ps2_bit(par);
        ps2_dat = ~bad_stop;
        if (mode == 2) begin @(negedge clock); aw_phase(32'h10); end
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b0;
        if (mode == 1) begin
            repeat (2) @(negedge clock);
            axi_read(32'h00, d);
            check("coinc_pop_data", d, (sb.size() != 0) ? sb.pop_front() : 32'd0);
        end else if (mode == 2) begin
            repeat (2) @(negedge clock);
            w_phase(64'h1, 8'h01);
            sb.delete();
        end else if (mode == 3) begin
`ifdef PS2_IRQ_EN
            repeat (3) @(negedge clock);
            check("irq_before_push", irq, 1'b0);
            @(negedge clock);
            check("irq_after_push", irq, 1'b1);
`endif
        end
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (HALF) @(negedge clock);
        if (mode != 2) begin
            if (!ok) m_ferr = 1;
            else if (sb.size() < DEPTH) sb.push_back(32'h100 | 32'(code));
            else m_ovf = 1;
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt [8];
        logic [31:0] d;
        vt[0] = '{8'h1C, 1'b0, 1'b0, 1'b1};
        vt[1] = '{8'h1C, 1'b1, 1'b0, 1'b0};
        vt[2] = '{8'h00, 1'b0, 1'b0, 1'b0};
        vt[3] = '{8'hFF, 1'b0, 1'b0, 1'b0};
        vt[4] = '{8'h80, 1'b0, 1'b1, 1'b0};
        vt[5] = '{8'hA5, 1'b0, 1'b0, 1'b1};
        vt[6] = '{8'h5A, 1'b0, 1'b0, 1'b1};
        vt[7] = '{8'h01, 1'b0, 1'b0, 1'b1};

        repeat (4) @(negedge clock);
        check("rst_ready", {arready, awready, wready, rvalid, bvalid}, 5'b11000);
        check("rst_outs", {rdata, rlast, rid, bid, rresp, bresp}, '0);
`ifdef PS2_IRQ_EN
        check("rst_irq", irq, 1'b0);
`endif
        resetn = 1'b1;
        chk_status("status_after_reset");

        for (int i = 0; i < 8; i++) begin
            ps2_send(vt[i].code, vt[i].bad_par, vt[i].bad_stop, 0);
            chk_status($sformatf("vec%0d_status", i));
            if (vt[i].rd_data) chk_data($sformatf("vec%0d_data", i));
        end
        while (sb.size() != 0) chk_data("drain_data");
        chk_data("empty_data");
        rd(32'h18, d);
        check("reg18_read", d, 32'd0);

        wr(32'h00, 64'h7, 8'hFF);
        wr(32'h10, 64'h4, 8'h02);
        chk_status("ignored_writes");
        wr(32'h10, 64'h4, 8'h01);
        apply_ctrl(4'h4);
        chk_status("clear_ferr");

        for (int i = 1; i <= DEPTH + 1; i++) ps2_send(8'(i), 1'b0, 1'b0, 0);
        chk_status("overflow_status");
        for (int i = 0; i < DEPTH; i++) chk_data("ovf_order");
        chk_data("ovf_empty");
        wr(32'h10, 64'h2, 8'h01);
        apply_ctrl(4'h2);

        for (int i = 0; i < DEPTH; i++) ps2_send(8'h40 + 8'(i), 1'b0, 1'b0, 0);
        chk_status("refill_full");
        ps2_send(8'h33, 1'b0, 1'b0, 1);
        chk_status("coinc_pop_status");
        for (int i = 0; i < DEPTH; i++) chk_data("coinc_order");

        ps2_send(8'h61, 1'b0, 1'b0, 0);
        ps2_send(8'h62, 1'b0, 1'b0, 0);
        ps2_send(8'h44, 1'b0, 1'b0, 2);
        chk_status("coinc_flush_status");
        chk_data("coinc_flush_data");

        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'(i & 1));
        repeat (TO + 10) @(negedge clock);
        m_ferr = 1;
        ps2_send(8'h5A, 1'b0, 1'b0, 0);
        chk_status("timeout_status");
        chk_data("timeout_data");

        wr(32'h10, 64'h6, 8'h01);
        apply_ctrl(4'h6);
        wr(32'h10, 64'h8, 8'h01);
        apply_ctrl(4'h8);
        rd(32'h10, d);
        check("ctrl_read", d, {28'd0, m_irq_en, 3'd0});
`ifdef PS2_IRQ_EN
        check("irq_idle", irq, 1'b0);
        ps2_send(8'h29, 1'b0, 1'b0, 3);
        @(negedge clock);
        axi_read(32'h00, d);
        check("irq_pop_data", d, sb.pop_front());
        check("irq_at_pop", irq, 1'b1);
        @(negedge clock);
        check("irq_after_pop", irq, 1'b0);
`endif

        @(negedge clock);
        aw_phase(32'h10);
        @(negedge clock);
        resetn = 1'b0;
        #1;
        check("reset_mid_write", {awready, wready, bvalid}, 3'b100);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        sb.delete(); m_ovf = 0; m_ferr = 0; m_irq_en = 0;
        chk_status("status_after_rereset");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
